// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: FSM state encoding, default
// debounce length and the counter width helper.
package key_pkg;

    // Debouncer FSM states. All four 2-bit encodings are in use; the
    // default branch in the FSM still forces recovery to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } key_state_e;

    // 10 samples = 10 ms at the 1 kHz system tick.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 10;

    // Bits needed to hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchroniser that brings the raw key level into the clk domain.
// Both flops reset to RST_VAL, so the output reads as "not pressed" out of reset.
module key_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // Next values for the chain: each stage takes the previous one.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchroniser flops with a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/key_test.sv
// Push-button debouncer and press detector. A synchronised key level must
// stay active for DEBOUNCE_CYCLES samples to produce one key_en pulse, and
// inactive for DEBOUNCE_CYCLES samples before another press can be accepted.
// The FSM state is held in state_q (type key_state_e) for observation.
module key_test
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic        ACTIVE_LEVEL    = 1'b1
) (
    input  logic clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_en
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          key_s;
    logic          act;
    key_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          key_en_q, key_en_d;

    key_sync2 #(
        .RST_VAL (~ACTIVE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .d     (key_in),
        .q     (key_s)
    );

    // Decisions are made on the synchronised "pressed" flag only.
    always_comb begin
        act     = (key_s == ACTIVE_LEVEL);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    // Next-state, counter and strobe logic of the debounce FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (act) begin
                    state_d = ST_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PRESS: begin
                if (!act) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_HELD;
                    cnt_d    = '0;
                    key_en_d = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            ST_HELD: begin
                if (!act) begin
                    state_d = ST_RELEASE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE: begin
                if (act) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM registers; reset aborts any count or pending pulse.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            key_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_en_q <= key_en_d;
        end
    end

    assign key_en = key_en_q;

endmodule

// File: tb/tb_key_test.sv
// Self-checking bench for key_test. A run-length reference model predicts
// key_en every cycle; directed phases also check pulse counts and latency.
// Handshake: none; key_in is a free-running level, key_en a one-cycle strobe.
module tb_key_test;

    localparam int   DC  = 10;
    localparam logic ACT = 1'b1;

    logic clk;
    logic sys_rst_n;
    logic key_in;
    logic key_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse = -1;
    int t0;

    // Reference model: key_in history through the synchroniser delay,
    // lengths of the current active / inactive runs, and whether a press
    // may currently be accepted.
    bit hist[$];
    bit armed;
    int act_run;
    int inact_run;
    bit exp_en;

    key_test #(
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LEVEL    (ACT)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_en    (key_en)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: update the model with the inputs seen at the rising edge,
    // then compare key_en on the falling edge.
    task automatic tick();
        bit a;
        @(posedge clk);
        cyc++;
        if (!sys_rst_n) begin
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            armed     = 1'b1;
            act_run   = 0;
            inact_run = 0;
            exp_en    = 1'b0;
        end else begin
            a = hist.pop_front();
            hist.push_back(key_in == ACT);
            exp_en = 1'b0;
            if (a) begin
                act_run++;
                inact_run = 0;
            end else begin
                inact_run++;
                act_run = 0;
            end
            if (armed && act_run == DC) begin
                exp_en = 1'b1;
                armed  = 1'b0;
            end else if (!armed && inact_run == DC) begin
                armed = 1'b1;
            end
        end
        @(negedge clk);
        checks++;
        assert (key_en === exp_en) else begin
            errors++;
            $error("FAIL key_en cyc=%0d got %b exp %b", cyc, key_en, exp_en);
        end
        if (key_en === 1'b1) begin
            pulses++;
            last_pulse = cyc;
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Directed phases followed by random bursts.
    initial begin
        sys_rst_n = 1'b0;
        key_in    = 1'b0;
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        armed = 1'b1;
        act_run = 0;
        inact_run = 0;
        exp_en = 1'b0;

        // Reset held 5 cycles with key_in toggling
        for (int i = 0; i < 5; i++) begin
            key_in = i[0];
            tick();
        end
        sys_rst_n = 1'b1;
        drive(1'b0, 20);
        check("reset_pulses", pulses, 0);

        // Long press: 15 high, 50 low
        pulses = 0;
        t0 = cyc;
        drive(1'b1, 15);
        drive(1'b0, 50);
        check("long_pulses", pulses, 1);
        check("long_latency", last_pulse - t0, DC + 2);

        // Glitches of 5 and 8 samples
        pulses = 0;
        drive(1'b1, 5);
        drive(1'b0, 50);
        drive(1'b1, 8);
        drive(1'b0, 50);
        check("glitch_pulses", pulses, 0);

        // Threshold: exactly DC accepted
        pulses = 0;
        t0 = cyc;
        drive(1'b1, DC);
        drive(1'b0, 50);
        check("thresh_dc_pulses", pulses, 1);
        check("thresh_dc_latency", last_pulse - t0, DC + 2);

        // Threshold: DC-1 rejected
        pulses = 0;
        drive(1'b1, DC - 1);
        drive(1'b0, 50);
        check("thresh_dcm1_pulses", pulses, 0);

        // Bouncy hold: dip of 3 absorbed in release
        pulses = 0;
        drive(1'b1, 15);
        drive(1'b0, 3);
        drive(1'b1, 20);
        drive(1'b0, 50);
        check("bouncy_pulses", pulses, 1);

        // Mid-count reset at count 6, key held high throughout
        pulses = 0;
        drive(1'b1, 8);
        sys_rst_n = 1'b0;
        drive(1'b1, 2);
        check("midreset_no_pulse", pulses, 0);
        sys_rst_n = 1'b1;
        t0 = cyc;
        drive(1'b1, 20);
        check("midreset_pulses", pulses, 1);
        check("midreset_latency", last_pulse - t0, DC + 2);
        drive(1'b0, 50);

        // Random bursts with occasional resets
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                sys_rst_n = 1'b0;
                drive(logic'($urandom_range(0, 1)), $urandom_range(1, 3));
                sys_rst_n = 1'b1;
            end
            drive(logic'(i % 2 == 0), $urandom_range(1, 25));
        end
        drive(1'b0, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
